// File: rtl/inv_ring_freq_meter_pkg.sv
// Shared types and default sizing for the inverter-ring frequency meter.
// The sync stage includes a divide-by-2 when INV_RING_FREQ_METER_DIV_EN is defined.
package inv_ring_freq_meter_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_WIN_W       = 12;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/inv_ring_freq_meter_if.sv
// Controller-side handshake bundle: START/WINDOW/ACK in, BUSY/VALID/COUNT/OVF out.
interface inv_ring_freq_meter_if
    import inv_ring_freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
);

    logic             start;
    logic [WIN_W-1:0] window;
    logic             ack;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output start, window, ack,
        input  busy, valid, count, ovf
    );

    modport slave (
        input  start, window, ack,
        output busy, valid, count, ovf
    );

endinterface

// File: rtl/inv_ring_freq_meter_sync.sv
// Brings the asynchronous ring output into the clk domain and emits a 1-cycle rising-edge pulse.
// With INV_RING_FREQ_METER_DIV_EN defined, a ring-clocked toggle flop halves the input first.
module inv_ring_freq_meter_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic edge_pulse
);

    logic                   sync_in;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;

`ifdef INV_RING_FREQ_METER_DIV_EN
    logic div_q;

    // Only flop in the design clocked by the ring; relaxes the input frequency limit by 2x.
    always_ff @(posedge ro_in or posedge rst) begin
        if (rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign sync_in = div_q;
`else
    assign sync_in = ro_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sync_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/inv_ring_freq_meter.sv
// Gated edge counter for a ring oscillator with a START/VALID/ACK result handshake.
// Build option INV_RING_FREQ_METER_DIV_EN (see the sync sub-module) makes COUNT read ring edges / 2.
module inv_ring_freq_meter
    import inv_ring_freq_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ro_in,
    inv_ring_freq_meter_if.slave bus
);

    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             valid_q;
    logic             ovf_q;
    logic             edge_pulse;
    logic             sat;
    logic [CNT_W-1:0] edge_next;

    inv_ring_freq_meter_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .ro_in     (ro_in),
        .edge_pulse(edge_pulse)
    );

    // Saturating increment; the final-cycle edge must be visible when COUNT is loaded.
    assign sat       = (edge_cnt == {CNT_W{1'b1}});
    assign edge_next = (edge_pulse && !sat) ? edge_cnt + CNT_W'(1) : edge_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        win_cnt  <= bus.window;
                        edge_cnt <= '0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        if (bus.window == '0) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                            count_q <= '0;
                        end else begin
                            state <= GATE;
                        end
                    end
                end
                GATE: begin
                    win_cnt  <= win_cnt - WIN_W'(1);
                    edge_cnt <= edge_next;
                    if (edge_pulse && sat) begin
                        ovf_q <= 1'b1;
                    end
                    if (win_cnt == WIN_W'(1)) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                        count_q <= edge_next;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

endmodule
